// File: rtl/jtcop_obj_rom_slot_if.sv
// Object ROM slot bus: client word-request side plus SDRAM burst side.
// The slave modport is the ROM slot itself; master is its environment.
interface jtcop_obj_rom_slot_if #(
    parameter int unsigned AW = 17
);
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          rom_ok;
    logic          sdram_req;
    logic [21:0]   sdram_addr;
    logic          sdram_ack;
    logic          sdram_dok;
    logic [15:0]   sdram_din;

    modport slave (
        input  rom_cs, rom_addr, sdram_ack, sdram_dok, sdram_din,
        output rom_data, rom_ok, sdram_req, sdram_addr
    );

    modport master (
        output rom_cs, rom_addr, sdram_ack, sdram_dok, sdram_din,
        input  rom_data, rom_ok, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtcop_obj_rom_slot.sv
// One-entry cached ROM responder: each 32-bit word miss becomes a
// two-beat 16-bit SDRAM burst, low half first.
module jtcop_obj_rom_slot #(
    parameter int unsigned AW     = 17,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jtcop_obj_rom_slot_if.slave    bus
);
    typedef enum logic [1:0] {StIdle, StReq, StBeat0, StBeat1} state_t;

    state_t        state;
    logic          valid;
    logic [AW-1:0] tag;
    logic [AW-1:0] pend;
    logic [31:0]   data;
    logic          req;
    logic [21:0]   addr;
    logic          hit;
    logic [21:0]   burst_addr;

    assign hit        = valid && (tag == bus.rom_addr);
    // 22-bit sum wraps silently; bit 0 is always 0 so bursts stay word aligned
    assign burst_addr = OFFSET + 22'({bus.rom_addr, 1'b0});

    assign bus.rom_ok     = bus.rom_cs && hit && (state == StIdle);
    assign bus.rom_data   = data;
    assign bus.sdram_req  = req;
    assign bus.sdram_addr = addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            valid <= 1'b0;
            tag   <= '0;
            pend  <= '0;
            data  <= '0;
            req   <= 1'b0;
            addr  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.rom_cs && !hit) begin
                        pend  <= bus.rom_addr;
                        addr  <= burst_addr;
                        req   <= 1'b1;
                        valid <= 1'b0;
                        state <= StReq;
                    end
                end
                StReq: begin
                    // a beat is only meaningful once the request is accepted
                    if (bus.sdram_ack) begin
                        req <= 1'b0;
                        if (bus.sdram_dok) begin
                            data[15:0] <= bus.sdram_din;
                            state      <= StBeat1;
                        end else begin
                            state <= StBeat0;
                        end
                    end
                end
                StBeat0: begin
                    if (bus.sdram_dok) begin
                        data[15:0] <= bus.sdram_din;
                        state      <= StBeat1;
                    end
                end
                StBeat1: begin
                    if (bus.sdram_dok) begin
                        data[31:16] <= bus.sdram_din;
                        tag         <= pend;
                        valid       <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_jtcop_obj_rom_slot.sv
// Directed bench for jtcop_obj_rom_slot: miss/hit, mid-fetch address change,
// ack+dok overlap, reset mid-burst and 22-bit address wrap.
module tb_jtcop_obj_rom_slot;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   req_rises = 0;
    int   rises_before;
    logic prev_req = 1'b0;

    always #5 clk = ~clk;

    jtcop_obj_rom_slot_if #(.AW(17)) b0 ();
    jtcop_obj_rom_slot_if #(.AW(17)) b1 ();
    jtcop_obj_rom_slot_if #(.AW(17)) b2 ();

    jtcop_obj_rom_slot #(.AW(17), .OFFSET(22'h080000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    jtcop_obj_rom_slot #(.AW(17), .OFFSET(22'h3C0000)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    jtcop_obj_rom_slot #(.AW(17), .OFFSET(22'h3FFFFE)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    // Count distinct requests issued by the main instance
    always @(negedge clk) begin
        prev_req <= b0.sdram_req;
        if (b0.sdram_req && !prev_req) req_rises <= req_rises + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] din);
        b0.sdram_dok = 1'b1;
        b0.sdram_din = din;
        tick();
        b0.sdram_dok = 1'b0;
    endtask

    task automatic ack();
        b0.sdram_ack = 1'b1;
        tick();
        b0.sdram_ack = 1'b0;
    endtask

    initial begin
        b0.rom_cs = 1'b0; b0.rom_addr = '0; b0.sdram_ack = 1'b0;
        b0.sdram_dok = 1'b0; b0.sdram_din = '0;
        b1.rom_cs = 1'b0; b1.rom_addr = '0; b1.sdram_ack = 1'b0;
        b1.sdram_dok = 1'b0; b1.sdram_din = '0;
        b2.rom_cs = 1'b0; b2.rom_addr = '0; b2.sdram_ack = 1'b0;
        b2.sdram_dok = 1'b0; b2.sdram_din = '0;

        // Reset state
        #2;
        check("rst_ok", 32'(b0.rom_ok), 32'd0);
        check("rst_req", 32'(b0.sdram_req), 32'd0);
        check("rst_saddr", 32'(b0.sdram_addr), 32'd0);
        check("rst_data", b0.rom_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: miss, dok before ack ignored, two beats
        b0.rom_cs = 1'b1; b0.rom_addr = 17'h00123;
        #1;
        check("t1_miss_ok", 32'(b0.rom_ok), 32'd0);
        tick();
        check("t1_req", 32'(b0.sdram_req), 32'd1);
        check("t1_saddr", 32'(b0.sdram_addr), 32'h080246);
        beat(16'hDEAD);
        check("t1_req_hold", 32'(b0.sdram_req), 32'd1);
        check("t1_saddr_hold", 32'(b0.sdram_addr), 32'h080246);
        ack();
        check("t1_req_drop", 32'(b0.sdram_req), 32'd0);
        beat(16'hBEEF);
        check("t1_ok_busy", 32'(b0.rom_ok), 32'd0);
        beat(16'h1234);
        check("t1_data", b0.rom_data, 32'h1234BEEF);
        check("t1_ok", 32'(b0.rom_ok), 32'd1);
        check("t1_req_idle", 32'(b0.sdram_req), 32'd0);

        // 2: hit held, stray ack ignored, cs drop is combinational
        rises_before = req_rises;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) b0.sdram_ack = 1'b1;
            tick();
            b0.sdram_ack = 1'b0;
            check("t2_hit_ok", 32'(b0.rom_ok), 32'd1);
            check("t2_no_req", 32'(b0.sdram_req), 32'd0);
        end
        b0.rom_cs = 1'b0;
        #1;
        check("t2_cs_drop", 32'(b0.rom_ok), 32'd0);
        b0.rom_cs = 1'b1;
        #1;
        check("t2_cs_raise", 32'(b0.rom_ok), 32'd1);
        tick();
        tick();
        check("t2_no_req2", 32'(b0.sdram_req), 32'd0);
        check("t2_req_count", 32'(req_rises - rises_before), 32'd0);

        // 4: ack and first dok in the same cycle
        rises_before = req_rises;
        b0.rom_addr = 17'h00050;
        #1;
        check("t4_miss_ok", 32'(b0.rom_ok), 32'd0);
        tick();
        check("t4_saddr", 32'(b0.sdram_addr), 32'h0800A0);
        b0.sdram_ack = 1'b1; b0.sdram_dok = 1'b1; b0.sdram_din = 16'hA5A5;
        tick();
        b0.sdram_ack = 1'b0; b0.sdram_dok = 1'b0;
        check("t4_req_drop", 32'(b0.sdram_req), 32'd0);
        check("t4_ok_busy", 32'(b0.rom_ok), 32'd0);
        beat(16'h5A5A);
        check("t4_data", b0.rom_data, 32'h5A5AA5A5);
        check("t4_ok", 32'(b0.rom_ok), 32'd1);
        tick();
        tick();
        check("t4_one_req", 32'(req_rises - rises_before), 32'd1);

        // 3: address change during BEAT0 does not abort the burst
        b0.rom_addr = 17'h00123;
        tick();
        check("t3_saddr_a", 32'(b0.sdram_addr), 32'h080246);
        ack();
        b0.rom_addr = 17'h00124;
        #1;
        check("t3_ok_beat0", 32'(b0.rom_ok), 32'd0);
        beat(16'h1111);
        check("t3_ok_beat1", 32'(b0.rom_ok), 32'd0);
        beat(16'h2222);
        check("t3_data_a", b0.rom_data, 32'h22221111);
        check("t3_ok_stale", 32'(b0.rom_ok), 32'd0);
        check("t3_req_idle", 32'(b0.sdram_req), 32'd0);
        tick();
        check("t3_req_b", 32'(b0.sdram_req), 32'd1);
        check("t3_saddr_b", 32'(b0.sdram_addr), 32'h080248);
        ack();
        beat(16'h3333);
        beat(16'h4444);
        check("t3_data_b", b0.rom_data, 32'h44443333);
        check("t3_ok_b", 32'(b0.rom_ok), 32'd1);

        // 5: reset in BEAT1
        b0.rom_addr = 17'h00300;
        tick();
        check("t5_saddr", 32'(b0.sdram_addr), 32'h080600);
        ack();
        beat(16'h7777);
        rst_n = 1'b0;
        #1;
        check("t5_rst_req", 32'(b0.sdram_req), 32'd0);
        check("t5_rst_ok", 32'(b0.rom_ok), 32'd0);
        check("t5_rst_data", b0.rom_data, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t5_post_ok", 32'(b0.rom_ok), 32'd0);
        tick();
        check("t5_new_req", 32'(b0.sdram_req), 32'd1);
        check("t5_new_saddr", 32'(b0.sdram_addr), 32'h080600);
        ack();
        beat(16'h9999);
        beat(16'h8888);
        check("t5_data", b0.rom_data, 32'h88889999);
        check("t5_ok", 32'(b0.rom_ok), 32'd1);

        // 6: 22-bit address wrap
        b1.rom_cs = 1'b1; b1.rom_addr = 17'h1FFFF;
        b2.rom_cs = 1'b1; b2.rom_addr = 17'h00001;
        tick();
        check("t6_req_a", 32'(b1.sdram_req), 32'd1);
        check("t6_saddr_a", 32'(b1.sdram_addr), 32'h3FFFFE);
        check("t6_req_b", 32'(b2.sdram_req), 32'd1);
        check("t6_saddr_b", 32'(b2.sdram_addr), 32'h000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
